tetris_vga_renderer: RTL and testbench

- Consumer end of the playfield interface driven by the game logic: reads the 20x10 grid of 4-bit cell codes and drives the Basys3 VGA port at 640x480@60 Hz.
- Generates VGA timing from the 100 MHz game clock and takes a tear-free grid snapshot once per frame.
- Pipelines cell lookup and palette mapping into registered 12-bit RGB.
- Emits a per-frame tick that the game logic may use as its fall-timer base.

---
 rtl/tetris_pkg.sv | 43 ++++
 rtl/vga_timing.sv | 62 ++++++
 rtl/tetris_vga_renderer.sv | 173 +++++++++++++++++
 tb/tb_tetris_vga_renderer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types, VGA 640x480@60 timing constants and the cell colour palette
// for the Tetris playfield renderer.
package tetris_pkg;

  localparam int unsigned GRID_ROWS = 20;
  localparam int unsigned GRID_COLS = 10;

  typedef logic [3:0] cell_t;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic [1:0] {
    RG_BLANK,
    RG_BG,
    RG_BORDER,
    RG_BOARD
  } region_t;

  function automatic logic [11:0] palette(input cell_t c);
    case (c)
      4'd0:    return 12'h111;
      4'd1:    return 12'h0FF;
      4'd2:    return 12'hFF0;
      4'd3:    return 12'hA0F;
      4'd4:    return 12'h0F0;
      4'd5:    return 12'hF00;
      4'd6:    return 12'h00F;
      4'd7:    return 12'hF80;
      default: return 12'hFFF;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock divider plus horizontal/vertical raster counters; exposes the
// current pixel position, the pixel strobe and unregistered active-low syncs.
module vga_timing
  import tetris_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = H_VISIBLE,
  parameter int unsigned H_FP    = H_FRONT,
  parameter int unsigned H_SW    = H_SYNC,
  parameter int unsigned H_BP    = H_BACK,
  parameter int unsigned V_VIS   = V_VISIBLE,
  parameter int unsigned V_FP    = V_FRONT,
  parameter int unsigned V_SW    = V_SYNC,
  parameter int unsigned V_BP    = V_BACK
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       pix_en,
  output logic       visible,
  output logic       hs_raw,
  output logic       vs_raw
);

  localparam int unsigned DW = $clog2(CLK_DIV);

  localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SW + V_BP - 1);
  localparam logic [9:0] HS_ON  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_VIS + H_FP + H_SW);
  localparam logic [9:0] VS_ON  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_VIS + V_FP + V_SW);

  logic [DW-1:0] div;

  assign pix_en  = (div == DW'(CLK_DIV - 1));
  assign visible = (h < 10'(H_VIS)) && (v < 10'(V_VIS));
  assign hs_raw  = !((h >= HS_ON) && (h < HS_OFF));
  assign vs_raw  = !((v >= VS_ON) && (v < VS_OFF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      if (pix_en) begin
        div <= '0;
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tetris_vga_renderer.sv
// Draws the 20x10 playfield snapshot, its border and background on VGA, with a
// two-stage pixel pipeline keeping RGB aligned with the delayed syncs.
module tetris_vga_renderer
  import tetris_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CELL_PX   = 20,
  parameter int unsigned BOARD_X0  = 220,
  parameter int unsigned BOARD_Y0  = 40,
  parameter int unsigned BORDER_PX = 2,
  parameter int unsigned H_VIS     = H_VISIBLE,
  parameter int unsigned H_FP      = H_FRONT,
  parameter int unsigned H_SW      = H_SYNC,
  parameter int unsigned H_BP      = H_BACK,
  parameter int unsigned V_VIS     = V_VISIBLE,
  parameter int unsigned V_FP      = V_FRONT,
  parameter int unsigned V_SW      = V_SYNC,
  parameter int unsigned V_BP      = V_BACK
) (
  input  logic                                       gm_clk,
  input  logic                                       gm_rst_n,
  input  logic [GRID_ROWS-1:0][GRID_COLS-1:0][3:0]   grid,
  output logic [3:0]                                 vga_r,
  output logic [3:0]                                 vga_g,
  output logic [3:0]                                 vga_b,
  output logic                                       vga_hs,
  output logic                                       vga_vs,
  output logic                                       frame_tick
);

  localparam int unsigned BW = GRID_COLS * CELL_PX;
  localparam int unsigned BH = GRID_ROWS * CELL_PX;
  localparam int unsigned SW = $clog2(CELL_PX);

  localparam logic [9:0] BX0    = 10'(BOARD_X0);
  localparam logic [9:0] BX1    = 10'(BOARD_X0 + BW);
  localparam logic [9:0] BY0    = 10'(BOARD_Y0);
  localparam logic [9:0] BY1    = 10'(BOARD_Y0 + BH);
  localparam logic [9:0] FXL    = 10'(BOARD_X0 - BORDER_PX);
  localparam logic [9:0] FXR    = 10'(BOARD_X0 + BW + BORDER_PX);
  localparam logic [9:0] FYT    = 10'(BOARD_Y0 - BORDER_PX);
  localparam logic [9:0] FYB    = 10'(BOARD_Y0 + BH + BORDER_PX);
  localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
  localparam logic [9:0] V_SNAP = 10'(V_VIS);
  localparam logic [SW-1:0] SUB_LAST = SW'(CELL_PX - 1);

  logic [9:0] h, v;
  logic       pix_en, visible, hs_raw, vs_raw;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SW    (H_SW),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SW    (V_SW),
    .V_BP    (V_BP)
  ) u_timing (
    .clk     (gm_clk),
    .rst_n   (gm_rst_n),
    .h       (h),
    .v       (v),
    .pix_en  (pix_en),
    .visible (visible),
    .hs_raw  (hs_raw),
    .vs_raw  (vs_raw)
  );

  logic [GRID_ROWS-1:0][GRID_COLS-1:0][3:0] snap;
  logic [SW-1:0] col_sub, row_sub;
  logic [3:0]    col_idx;
  logic [4:0]    row_idx;

  logic    snap_now, in_board, in_frame;
  region_t region;

  region_t     region_s1;
  cell_t       cell_s1;
  logic        gridline_s1, hs_s1, vs_s1, valid_s1;
  logic [11:0] rgb_next;

  assign snap_now = pix_en && (h == '0) && (v == V_SNAP);
  assign in_board = (h >= BX0) && (h < BX1) && (v >= BY0) && (v < BY1);
  assign in_frame = (h >= FXL) && (h < FXR) && (v >= FYT) && (v < FYB);

  always_comb begin
    region = RG_BG;
    if (!visible)      region = RG_BLANK;
    else if (in_board) region = RG_BOARD;
    else if (in_frame) region = RG_BORDER;
  end

  always_comb begin
    rgb_next = '0;
    case (region_s1)
      RG_BOARD:  rgb_next = gridline_s1 ? 12'h000 : palette(cell_s1);
      RG_BORDER: rgb_next = 12'h888;
      default:   rgb_next = '0;
    endcase
    if (!valid_s1) rgb_next = '0;
  end

  // Cell counters track the pixel the raster counters currently hold: they are
  // zeroed one pixel/line ahead of the board edge and stop on its last pixel/line.
  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      snap       <= '0;
      frame_tick <= 1'b0;
      col_sub    <= '0;
      col_idx    <= '0;
      row_sub    <= '0;
      row_idx    <= '0;
    end else begin
      frame_tick <= snap_now;
      if (snap_now) snap <= grid;
      if (pix_en) begin
        if (h == BX0 - 10'd1) begin
          col_sub <= '0;
          col_idx <= '0;
        end else if ((h >= BX0) && (h < BX1 - 10'd1)) begin
          if (col_sub == SUB_LAST) begin
            col_sub <= '0;
            col_idx <= col_idx + 4'd1;
          end else begin
            col_sub <= col_sub + 1'b1;
          end
        end
        if (h == H_LAST) begin
          if (v == BY0 - 10'd1) begin
            row_sub <= '0;
            row_idx <= '0;
          end else if ((v >= BY0) && (v < BY1 - 10'd1)) begin
            if (row_sub == SUB_LAST) begin
              row_sub <= '0;
              row_idx <= row_idx + 5'd1;
            end else begin
              row_sub <= row_sub + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      region_s1   <= RG_BLANK;
      cell_s1     <= '0;
      gridline_s1 <= 1'b0;
      hs_s1       <= 1'b1;
      vs_s1       <= 1'b1;
      valid_s1    <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
    end else if (pix_en) begin
      region_s1   <= region;
      cell_s1     <= snap[row_idx][col_idx];
      gridline_s1 <= (col_sub == '0) || (row_sub == '0);
      hs_s1       <= hs_raw;
      vs_s1       <= vs_raw;
      valid_s1    <= 1'b1;
      {vga_r, vga_g, vga_b} <= rgb_next;
      vga_hs      <= hs_s1;
      vga_vs      <= vs_s1;
    end
  end

endmodule

// File: tb/tb_tetris_vga_renderer.sv
// Directed bench: a full-size instance for real VGA sync timing and a shrunken
// instance (small cells/raster) for snapshot, palette, region and reset checks.
module tb_tetris_vga_renderer;

  logic gm_clk = 1'b0;
  logic rst_n;
  logic [19:0][9:0][3:0] grid;

  logic [3:0] sm_r, sm_g, sm_b, fl_r, fl_g, fl_b;
  logic sm_hs, sm_vs, sm_ft, fl_hs, fl_vs, fl_ft;

  int cyc;
  int checks = 0;
  int passes = 0;

  always #5 gm_clk = ~gm_clk;

  always @(posedge gm_clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  tetris_vga_renderer #(
    .CLK_DIV(2), .CELL_PX(4), .BOARD_X0(8), .BOARD_Y0(4), .BORDER_PX(2),
    .H_VIS(56), .H_FP(2), .H_SW(4), .H_BP(2),
    .V_VIS(92), .V_FP(2), .V_SW(2), .V_BP(2)
  ) sm (
    .gm_clk(gm_clk), .gm_rst_n(rst_n), .grid(grid),
    .vga_r(sm_r), .vga_g(sm_g), .vga_b(sm_b),
    .vga_hs(sm_hs), .vga_vs(sm_vs), .frame_tick(sm_ft)
  );

  tetris_vga_renderer fl (
    .gm_clk(gm_clk), .gm_rst_n(rst_n), .grid(grid),
    .vga_r(fl_r), .vga_g(fl_g), .vga_b(fl_b),
    .vga_hs(fl_hs), .vga_vs(fl_vs), .frame_tick(fl_ft)
  );

  // Small raster: 64 pixels x 98 lines, 2 gm_clk per pixel, 2-pixel pipeline.
  localparam int SD = 2;
  localparam int SHT = 64;
  localparam int SFRAME = 64 * 98;

  function automatic int pix_cyc(input int f, input int h, input int v);
    return SD * (f * SFRAME + v * SHT + h + 2);
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge gm_clk);
    if (cyc != t) begin
      checks++;
      $display("FAIL sample_window: wanted cycle %0d, reached %0d", t, cyc);
    end
  endtask

  typedef struct {
    bit          wr;
    int          f;
    int          h;
    int          v;
    logic [11:0] rgb;
  } pix_vec_t;

  typedef struct {
    int   c;
    int   sig;
    logic exp;
  } tim_vec_t;

  pix_vec_t pv[$];
  tim_vec_t tv[$];
  int n_first;

  function automatic logic sig_val(input int s);
    case (s)
      0:       return sm_hs;
      1:       return sm_vs;
      2:       return sm_ft;
      default: return fl_hs;
    endcase
  endfunction

  task automatic run_timing();
    string nm[4] = '{"sm_hs", "sm_vs", "sm_tick", "fl_hs"};
    for (int i = 0; i < tv.size(); i++) begin
      wait_cyc(tv[i].c);
      check($sformatf("%s@%0d", nm[tv[i].sig], tv[i].c),
            {11'b0, sig_val(tv[i].sig)}, {11'b0, tv[i].exp});
    end
  endtask

  task automatic run_pix(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      wait_cyc(pix_cyc(pv[i].f, pv[i].h, pv[i].v));
      if (pv[i].wr) begin
        grid[19][9] = 4'd9;
        grid[18][0] = 4'd3;
      end else begin
        check($sformatf("pix f%0d (%0d,%0d)", pv[i].f, pv[i].h, pv[i].v),
              {sm_r, sm_g, sm_b}, pv[i].rgb);
      end
    end
  endtask

  task automatic add(input int f, input int h, input int v, input logic [11:0] rgb);
    pv.push_back('{1'b0, f, h, v, rgb});
  endtask

  initial begin
    rst_n = 1'b0;
    grid  = '0;

    // Frame 0 after power-up: snapshot still zero.
    add(0, 8, 4, 12'h000);   add(0, 9, 5, 12'h111);   add(0, 45, 81, 12'h111);
    // Frame 1: first snapshot visible; row 0 holds codes 1,2..8,15,0.
    add(1, 20, 1, 12'h000);  add(1, 6, 2, 12'h888);   add(1, 20, 2, 12'h888);
    add(1, 20, 3, 12'h888);  add(1, 8, 4, 12'h000);   add(1, 9, 5, 12'h0FF);
    add(1, 12, 5, 12'h000);  add(1, 13, 5, 12'hFF0);  add(1, 17, 5, 12'hA0F);
    add(1, 21, 5, 12'h0F0);  add(1, 25, 5, 12'hF00);  add(1, 29, 5, 12'h00F);
    add(1, 33, 5, 12'hF80);  add(1, 37, 5, 12'hFFF);  add(1, 41, 5, 12'hFFF);
    add(1, 45, 5, 12'h111);  add(1, 11, 7, 12'h0FF);  add(1, 9, 8, 12'h000);
    add(1, 10, 9, 12'h111);
    pv.push_back('{1'b1, 1, 0, 20, 12'h000});
    add(1, 5, 40, 12'h000);  add(1, 6, 40, 12'h888);  add(1, 7, 40, 12'h888);
    add(1, 48, 40, 12'h888); add(1, 49, 40, 12'h888); add(1, 50, 40, 12'h000);
    add(1, 54, 40, 12'h000); add(1, 9, 77, 12'h111);  add(1, 45, 81, 12'h111);
    add(1, 47, 83, 12'h111); add(1, 20, 85, 12'h888); add(1, 20, 86, 12'h000);
    // Frame 2: mid-frame-1 grid writes now visible.
    add(2, 9, 5, 12'h0FF);   add(2, 9, 77, 12'hA0F);  add(2, 44, 81, 12'h000);
    add(2, 45, 81, 12'hFFF); add(2, 47, 83, 12'hFFF);
    n_first = pv.size();
    // Frame 0 after the mid-frame reset: snapshot cleared again.
    add(0, 8, 4, 12'h000);   add(0, 9, 5, 12'h111);   add(0, 9, 77, 12'h111);
    add(0, 45, 81, 12'h111);

    tv = '{
      '{119, 0, 1'b1},   '{120, 0, 1'b0},   '{127, 0, 1'b0},   '{128, 0, 1'b1},
      '{2631, 3, 1'b1},  '{2632, 3, 1'b0},  '{3015, 3, 1'b0},  '{3016, 3, 1'b1},
      '{5831, 3, 1'b1},  '{5832, 3, 1'b0},
      '{11777, 2, 1'b0}, '{11778, 2, 1'b1}, '{11779, 2, 1'b0},
      '{12035, 1, 1'b1}, '{12036, 1, 1'b0}, '{12291, 1, 1'b0}, '{12292, 1, 1'b1},
      '{24321, 2, 1'b0}, '{24322, 2, 1'b1}, '{24323, 2, 1'b0}
    };

    repeat (3) @(negedge gm_clk);
    check("rst sm_rgb", {sm_r, sm_g, sm_b}, 12'h000);
    check("rst sm_hs", {11'b0, sm_hs}, 12'h001);
    check("rst sm_vs", {11'b0, sm_vs}, 12'h001);
    check("rst sm_tick", {11'b0, sm_ft}, 12'h000);
    check("rst fl_rgb", {fl_r, fl_g, fl_b}, 12'h000);
    check("rst fl_hs", {11'b0, fl_hs}, 12'h001);
    check("rst fl_vs", {11'b0, fl_vs}, 12'h001);
    check("rst fl_tick", {11'b0, fl_ft}, 12'h000);

    rst_n = 1'b1;
    grid[0][0] = 4'd1;
    for (int c = 1; c <= 7; c++) grid[0][c] = 4'(c + 1);
    grid[0][8] = 4'd15;

    fork
      run_timing();
      run_pix(0, n_first - 1);
    join

    // Reset lands while the small board is driving FFF.
    rst_n = 1'b0;
    #1;
    check("midrst sm_rgb", {sm_r, sm_g, sm_b}, 12'h000);
    check("midrst sm_hs", {11'b0, sm_hs}, 12'h001);
    check("midrst sm_vs", {11'b0, sm_vs}, 12'h001);
    check("midrst sm_tick", {11'b0, sm_ft}, 12'h000);
    check("midrst fl_hs", {11'b0, fl_hs}, 12'h001);
    repeat (3) @(negedge gm_clk);
    rst_n = 1'b1;
    run_pix(n_first, pv.size() - 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
